fc_layer_sched: RTL and testbench

Sequencer for the fully connected layer: it steps the 30-input MAC datapath over every output neuron of a layer. For each neuron it reads that neuron's weight row and bias from a synchronous weight ROM, drives them to the MAC stage, and captures the registered 32-bit result. It streams the per-neuron results out and tracks a running signed argmax, reporting the winning class at the end of the layer. It sits between the feature-vector producer and the classifier output, and owns the weight ROM read port.

---
 rtl/fc_pkg.sv | 24 ++
 rtl/fc_argmax.sv | 47 ++++
 rtl/fc_layer_sched.sv | 147 ++++++++++++++
 tb/tb_fc_layer_sched.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared constants, state encoding and result/class types for the
// fully connected layer sequencer.
package fc_pkg;

  localparam int N_IN     = 30;
  localparam int N_OUT    = 10;
  localparam int ADDR_W   = $clog2(N_OUT);
  localparam int DATA_W   = 24;
  localparam int WEIGHT_W = 16;
  localparam int BIAS_W   = 16;
  localparam int RES_W    = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    CAPT,
    DONE
  } state_t;

  typedef logic signed [RES_W-1:0] result_t;
  typedef logic [ADDR_W-1:0]       class_t;

endpackage

// File: rtl/fc_argmax.sv
// Running signed argmax over the neuron results of one layer; the next-state
// values are exported so the sequencer can publish the final winner on the
// same edge as the last update.
module fc_argmax
  import fc_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_clear,
  input  logic    i_update,
  input  logic    i_first,
  input  result_t i_value,
  input  class_t  i_idx,
  output result_t o_max_next,
  output class_t  o_class_next
);

  result_t max_q, max_d;
  class_t  class_q, class_d;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    max_d   = max_q;
    class_d = class_q;
    if (i_clear) begin
      max_d   = '0;
      class_d = '0;
    end else if (i_update && (i_first || (i_value > max_q))) begin
      max_d   = i_value;
      class_d = i_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q   <= '0;
      class_q <= '0;
    end else begin
      max_q   <= max_d;
      class_q <= class_d;
    end
  end

  assign o_max_next   = max_d;
  assign o_class_next = class_d;

endmodule

// File: rtl/fc_layer_sched.sv
// Steps the MAC stage over every output neuron: ROM fetch, operand pass-through,
// result capture, and a final argmax report at the end of the layer.
module fc_layer_sched
  import fc_pkg::*;
(
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_start,
  input  logic [N_IN-1:0][DATA_W-1:0]        i_data,
  output logic                               o_busy,
  output logic                               o_rom_en,
  output logic [ADDR_W-1:0]                  o_rom_addr,
  input  logic [N_IN-1:0][WEIGHT_W-1:0]      i_rom_weight,
  input  logic [BIAS_W-1:0]                  i_rom_bias,
  output logic [N_IN-1:0][DATA_W-1:0]        o_fc_data,
  output logic [N_IN-1:0][WEIGHT_W-1:0]      o_fc_weight,
  output logic [BIAS_W-1:0]                  o_fc_bias,
  input  logic [RES_W-1:0]                   i_fc_output,
  output logic                               o_res_valid,
  output logic [ADDR_W-1:0]                  o_res_idx,
  output logic [RES_W-1:0]                   o_res,
  output logic                               o_done,
  output logic [ADDR_W-1:0]                  o_class,
  output logic [RES_W-1:0]                   o_max
);

  state_t                     state_q, state_d;
  class_t                     k_q, k_d;
  logic [N_IN-1:0][DATA_W-1:0] data_q, data_d;
  logic                       busy_q, busy_d;
  logic                       rom_en_q, rom_en_d;
  class_t                     rom_addr_q, rom_addr_d;
  logic                       res_valid_q, res_valid_d;
  class_t                     res_idx_q, res_idx_d;
  logic                       done_q, done_d;
  class_t                     class_q, class_d;
  result_t                    max_q, max_d;

  logic    start_accept;
  logic    capture;
  result_t amax_next;
  class_t  aclass_next;

  assign start_accept = (state_q == IDLE) && i_start;
  assign capture      = (state_q == CAPT);

  fc_argmax u_argmax (
    .clk          (i_clk),
    .rst          (i_rst),
    .i_clear      (start_accept),
    .i_update     (capture),
    .i_first      (k_q == '0),
    .i_value      (result_t'(i_fc_output)),
    .i_idx        (k_q),
    .o_max_next   (amax_next),
    .o_class_next (aclass_next)
  );

  // Outputs are computed one state ahead so every strobe is a flop.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    data_d      = data_q;
    rom_en_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    res_valid_d = 1'b0;
    res_idx_d   = res_idx_q;
    done_d      = 1'b0;
    class_d     = class_q;
    max_d       = max_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d    = FETCH;
          data_d     = i_data;
          k_d        = '0;
          rom_en_d   = 1'b1;
          rom_addr_d = '0;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        state_d     = CAPT;
        res_valid_d = 1'b1;
        res_idx_d   = k_q;
      end
      CAPT: begin
        if (k_q == class_t'(N_OUT - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          class_d = aclass_next;
          max_d   = amax_next;
        end else begin
          state_d    = FETCH;
          k_d        = k_q + 1'b1;
          rom_en_d   = 1'b1;
          rom_addr_d = k_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      done_q      <= 1'b0;
      class_q     <= '0;
      max_q       <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      done_q      <= done_d;
      class_q     <= class_d;
      max_q       <= max_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_rom_en    = rom_en_q;
  assign o_rom_addr  = rom_addr_q;
  assign o_fc_data   = data_q;
  assign o_fc_weight = i_rom_weight;
  assign o_fc_bias   = i_rom_bias;
  assign o_res_valid = res_valid_q;
  assign o_res_idx   = res_idx_q;
  assign o_res       = res_valid_q ? i_fc_output : '0;
  assign o_done      = done_q;
  assign o_class     = class_q;
  assign o_max       = max_q;

endmodule

// File: tb/tb_fc_layer_sched.sv
// Directed bench for fc_layer_sched with a behavioural weight ROM and a
// registered MAC stand-in (Q8 feature data, bias added after the shift).
module tb_fc_layer_sched;
  import fc_pkg::*;

  logic                          i_clk = 1'b0;
  logic                          i_rst;
  logic                          i_start;
  logic [N_IN-1:0][DATA_W-1:0]   i_data;
  logic                          o_busy;
  logic                          o_rom_en;
  logic [ADDR_W-1:0]             o_rom_addr;
  logic [N_IN-1:0][WEIGHT_W-1:0] i_rom_weight;
  logic [BIAS_W-1:0]             i_rom_bias;
  logic [N_IN-1:0][DATA_W-1:0]   o_fc_data;
  logic [N_IN-1:0][WEIGHT_W-1:0] o_fc_weight;
  logic [BIAS_W-1:0]             o_fc_bias;
  logic [RES_W-1:0]              i_fc_output;
  logic                          o_res_valid;
  logic [ADDR_W-1:0]             o_res_idx;
  logic [RES_W-1:0]              o_res;
  logic                          o_done;
  logic [ADDR_W-1:0]             o_class;
  logic [RES_W-1:0]              o_max;

  logic [N_IN-1:0][WEIGHT_W-1:0] romW [N_OUT];
  logic [BIAS_W-1:0]             romB [N_OUT];
  logic [N_IN-1:0][DATA_W-1:0]   featData;

  int cyc = 0;
  int startCyc = 0;
  int vectors = 0;
  int miscompares = 0;

  fc_layer_sched dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_data       (i_data),
    .o_busy       (o_busy),
    .o_rom_en     (o_rom_en),
    .o_rom_addr   (o_rom_addr),
    .i_rom_weight (i_rom_weight),
    .i_rom_bias   (i_rom_bias),
    .o_fc_data    (o_fc_data),
    .o_fc_weight  (o_fc_weight),
    .o_fc_bias    (o_fc_bias),
    .i_fc_output  (i_fc_output),
    .o_res_valid  (o_res_valid),
    .o_res_idx    (o_res_idx),
    .o_res        (o_res),
    .o_done       (o_done),
    .o_class      (o_class),
    .o_max        (o_max)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic logic [31:0] macCalc(input logic [N_IN-1:0][DATA_W-1:0] d,
                                          input logic [N_IN-1:0][WEIGHT_W-1:0] w,
                                          input logic [BIAS_W-1:0] b);
    longint acc = 0;
    for (int i = 0; i < N_IN; i++)
      acc += longint'($signed(d[i])) * longint'($signed(w[i]));
    acc = acc >>> 8;
    return 32'(acc + longint'($signed(b)));
  endfunction

  // Synchronous ROM: row appears one cycle after the enable
  always @(posedge i_clk) begin
    if (o_rom_en) begin
      i_rom_weight <= romW[o_rom_addr];
      i_rom_bias   <= romB[o_rom_addr];
    end
  end

  // MAC stand-in registers its result one cycle after the operands
  always @(posedge i_clk) i_fc_output <= macCalc(o_fc_data, o_fc_weight, o_fc_bias);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearRom();
    for (int k = 0; k < N_OUT; k++) begin
      romW[k] = '0;
      romB[k] = '0;
    end
    featData = '0;
  endtask

  task automatic applyStimulus();
    @(negedge i_clk);
    i_data  = featData;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    startCyc = cyc;
    i_start  = 1'b0;
  endtask

  task automatic runLayer(input string name, input logic [ADDR_W-1:0] expClass,
                          input logic [31:0] expMax, input bit pulses);
    int resCount = 0;
    int doneCount = 0;
    int rel;
    applyStimulus();
    for (int n = 0; n < 40; n++) begin
      @(negedge i_clk);
      rel = cyc - startCyc + 1;
      i_start = pulses && (rel == 5 || rel == 20);
      checkOutput({name, " busy"}, 32'(o_busy), 32'd1);
      if (o_res_valid) begin
        checkOutput({name, " res_idx"}, 32'(o_res_idx), 32'(resCount));
        checkOutput({name, " res_cycle"}, 32'(rel), 32'(3 * resCount + 3));
        if (resCount < N_OUT)
          checkOutput({name, " res"}, o_res, macCalc(featData, romW[resCount], romB[resCount]));
        resCount++;
      end
      if (o_done) begin
        checkOutput({name, " done_cycle"}, 32'(rel), 32'd31);
        checkOutput({name, " class"}, 32'(o_class), 32'(expClass));
        checkOutput({name, " max"}, o_max, expMax);
        doneCount++;
        break;
      end
    end
    i_start = 1'b0;
    checkOutput({name, " res_count"}, 32'(resCount), 32'(N_OUT));
    checkOutput({name, " done_count"}, 32'(doneCount), 32'd1);
  endtask

  task automatic setBiasRamp();
    clearRom();
    for (int k = 0; k < N_OUT; k++) romB[k] = 16'(k);
  endtask

  initial begin
    int doneSeen;
    int resSeen;
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_data  = '0;
    clearRom();
    #12;
    checkOutput("reset busy", 32'(o_busy), 32'd0);
    checkOutput("reset rom_en", 32'(o_rom_en), 32'd0);
    checkOutput("reset rom_addr", 32'(o_rom_addr), 32'd0);
    checkOutput("reset res_valid", 32'(o_res_valid), 32'd0);
    checkOutput("reset res", o_res, 32'd0);
    checkOutput("reset done", 32'(o_done), 32'd0);
    checkOutput("reset class", 32'(o_class), 32'd0);
    checkOutput("reset max", o_max, 32'd0);
    checkOutput("reset fc_data", 32'(o_fc_data[0]), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    setBiasRamp();
    runLayer("ramp", 4'd9, 32'd9, 1'b0);

    clearRom();
    for (int k = 0; k < N_OUT; k++) romB[k] = 16'd5;
    runLayer("tie", 4'd0, 32'd5, 1'b0);

    clearRom();
    for (int k = 0; k < N_OUT; k++) romB[k] = 16'hFF9C;
    romB[3] = 16'hFFFF;
    runLayer("negative", 4'd3, 32'hFFFF_FFFF, 1'b0);

    clearRom();
    featData[0] = 24'd256;
    romW[2][0]  = 16'd7;
    runLayer("weight", 4'd2, 32'd7, 1'b0);
    checkOutput("weight fc_data held", 32'(o_fc_data[0]), 32'd256);

    setBiasRamp();
    runLayer("restart_ignored", 4'd9, 32'd9, 1'b1);

    applyStimulus();
    for (int n = 0; n < 10; n++) @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    checkOutput("abort busy", 32'(o_busy), 32'd0);
    checkOutput("abort class", 32'(o_class), 32'd0);
    checkOutput("abort max", o_max, 32'd0);
    checkOutput("abort res_valid", 32'(o_res_valid), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    doneSeen = 0;
    resSeen  = 0;
    for (int n = 0; n < 35; n++) begin
      @(negedge i_clk);
      if (o_done) doneSeen++;
      if (o_res_valid) resSeen++;
    end
    checkOutput("abort no done", 32'(doneSeen), 32'd0);
    checkOutput("abort no res", 32'(resSeen), 32'd0);
    checkOutput("abort idle busy", 32'(o_busy), 32'd0);

    runLayer("after_reset", 4'd9, 32'd9, 1'b0);
    @(negedge i_clk);
    checkOutput("final busy", 32'(o_busy), 32'd0);
    checkOutput("final class held", 32'(o_class), 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
